// File: rtl/adc_i2c_target.sv
// I2C target emulating an ADS1115-style four-register map (conversion, config, lo/hi threshold).
// Optional SCL-low bus timeout is enabled by defining ADC_I2C_TARGET_TIMEOUT_EN.
module adc_i2c_target #(
    parameter logic [6:0]  ADDRESS        = 7'b1001001,
    parameter logic [15:0] CONFIG_RESET   = 16'h8583,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2700000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl,
    input  logic        sdaIn,
    output logic        sdaOut,
    output logic        isSending,
    input  logic [15:0] convValue,
    input  logic        convLoad,
    output logic [15:0] configReg,
    output logic [15:0] loThresh,
    output logic [15:0] hiThresh,
    output logic        configWritten,
    output logic        convStart
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t      state;
    logic        scl_p0, scl_p1, scl_p2;
    logic        sda_p0, sda_p1, sda_p2;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift;
    logic [1:0]  ptr;
    logic        byte_msb;
    logic        rw;
    logic [7:0]  msb_hold;
    logic [15:0] snap;
    logic [15:0] conv_reg;
    logic [15:0] sel_value;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic        scl_rise, scl_fall, start_det, stop_det, bus_ok, last_bit, timeout;

    // Stage boundary: two-flop synchronizers plus a history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            {scl_p0, scl_p1, scl_p2} <= 3'b111;
            {sda_p0, sda_p1, sda_p2} <= 3'b111;
        end else begin
            scl_p0 <= scl;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= sdaIn;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    // While we hold SDA low the line reflects our own drive, not the initiator.
    assign bus_ok    = ~(isSending & ~sdaOut);
    assign scl_rise  = scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 & scl_p2;
    assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1 & bus_ok;
    assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1 & bus_ok;
    assign rx_byte   = {shift, sda_p1};
    assign last_bit  = (bit_cnt == 3'd7);
    assign tx_byte   = byte_msb ? snap[15:8] : snap[7:0];

    always_comb begin
        sel_value = conv_reg;
        case (ptr)
            2'd1:    sel_value = configReg;
            2'd2:    sel_value = loThresh;
            2'd3:    sel_value = hiThresh;
            default: sel_value = conv_reg;
        endcase
    end

`ifdef ADC_I2C_TARGET_TIMEOUT_EN
    logic [31:0] to_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= 32'd0;
        end else if (scl_p1 || state == IDLE || state == IGNORE) begin
            to_cnt <= 32'd0;
        end else if (!timeout) begin
            to_cnt <= to_cnt + 32'd1;
        end
    end

    assign timeout = (to_cnt >= TIMEOUT_CYCLES);
`else
    assign timeout = 1'b0 & (TIMEOUT_CYCLES != 32'd0);
`endif

    // Stage boundary: protocol FSM acting on synchronized edges
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            shift         <= 7'd0;
            ptr           <= 2'd0;
            byte_msb      <= 1'b1;
            rw            <= 1'b0;
            msb_hold      <= 8'd0;
            snap          <= 16'd0;
            conv_reg      <= 16'd0;
            configReg     <= CONFIG_RESET;
            loThresh      <= 16'h8000;
            hiThresh      <= 16'h7FFF;
            sdaOut        <= 1'b1;
            isSending     <= 1'b0;
            configWritten <= 1'b0;
            convStart     <= 1'b0;
        end else begin
            configWritten <= 1'b0;
            convStart     <= 1'b0;
            if (convLoad)
                conv_reg <= convValue;

            if (start_det || stop_det || timeout) begin
                state     <= start_det ? ADDR : IDLE;
                bit_cnt   <= 3'd0;
                sdaOut    <= 1'b1;
                isSending <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    ADDR: begin
                        shift   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            rw    <= sda_p1;
                            state <= (rx_byte[7:1] == ADDRESS) ? ADDR_ACK : IGNORE;
                        end
                    end
                    PTR: begin
                        shift   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            ptr   <= rx_byte[1:0];
                            state <= PTR_ACK;
                        end
                    end
                    WDATA: begin
                        shift   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            byte_msb <= ~byte_msb;
                            state    <= WDATA_ACK;
                            if (byte_msb) begin
                                msb_hold <= rx_byte;
                            end else begin
                                case (ptr)
                                    2'd1: begin
                                        configReg     <= {1'b1, msb_hold[6:0], rx_byte};
                                        configWritten <= 1'b1;
                                        convStart     <= msb_hold[7];
                                    end
                                    2'd2:    loThresh <= {msb_hold, rx_byte};
                                    2'd3:    hiThresh <= {msb_hold, rx_byte};
                                    default: ;
                                endcase
                            end
                        end
                    end
                    RDATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit)
                            state <= RDATA_ACK;
                    end
                    RDATA_ACK: begin
                        if (sda_p1) begin
                            state <= IGNORE;
                        end else begin
                            state    <= RDATA;
                            byte_msb <= ~byte_msb;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    // First fall drives the ACK, second fall ends the ACK slot.
                    ADDR_ACK: begin
                        if (!isSending) begin
                            isSending <= 1'b1;
                            sdaOut    <= 1'b0;
                            snap      <= sel_value;
                        end else if (rw) begin
                            state    <= RDATA;
                            byte_msb <= 1'b1;
                            bit_cnt  <= 3'd0;
                            sdaOut   <= snap[15];
                        end else begin
                            state     <= PTR;
                            isSending <= 1'b0;
                            sdaOut    <= 1'b1;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (!isSending) begin
                            isSending <= 1'b1;
                            sdaOut    <= 1'b0;
                        end else begin
                            if (state == PTR_ACK)
                                byte_msb <= 1'b1;
                            state     <= WDATA;
                            isSending <= 1'b0;
                            sdaOut    <= 1'b1;
                        end
                    end
                    RDATA: begin
                        isSending <= 1'b1;
                        sdaOut    <= tx_byte[3'd7 - bit_cnt];
                    end
                    RDATA_ACK: begin
                        isSending <= 1'b0;
                        sdaOut    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_i2c_target.sv
// Bench for adc_i2c_target: bit-banged I2C initiator, table of write transactions plus
// hand-written read, repeated-START, snapshot and reset sequences.
module tb_adc_i2c_target;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        tb_scl, tb_sda;
    logic        scl, sdaIn, sdaOut, isSending;
    logic [15:0] convValue;
    logic        convLoad;
    logic [15:0] configReg, loThresh, hiThresh;
    logic        configWritten, convStart;

    int tests = 0;
    int fails = 0;
    int cw_cnt = 0;
    int cs_cnt = 0;

    always #5 clk = ~clk;

    assign scl   = tb_scl;
    assign sdaIn = tb_sda & ~(isSending & ~sdaOut);

    adc_i2c_target #(.TIMEOUT_CYCLES(32'd300)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sdaIn(sdaIn), .sdaOut(sdaOut),
        .isSending(isSending), .convValue(convValue), .convLoad(convLoad),
        .configReg(configReg), .loThresh(loThresh), .hiThresh(hiThresh),
        .configWritten(configWritten), .convStart(convStart)
    );

    always @(posedge clk) begin
        if (configWritten) cw_cnt <= cw_cnt + 1;
        if (convStart)     cs_cnt <= cs_cnt + 1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  ptr;
        logic [15:0] data;
        int          exp_acks;
        logic [15:0] exp_cfg;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
        int          exp_cw;
        int          exp_cs;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        tb_sda = 1'b1; qwait();
        tb_scl = 1'b1; qwait();
        tb_sda = 1'b0; qwait();
        tb_scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        tb_sda = 1'b0; qwait();
        tb_scl = 1'b1; qwait();
        tb_sda = 1'b1; qwait();
    endtask

    task automatic write_bit(input logic b);
        tb_sda = b; qwait();
        tb_scl = 1'b1; qwait(); qwait();
        tb_scl = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        tb_sda = 1'b1; qwait();
        tb_scl = 1'b1; qwait();
        b = sdaIn; qwait();
        tb_scl = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] v, input logic ack_bit);
        logic b;
        v = 8'd0;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            v = {v[6:0], b};
        end
        write_bit(ack_bit);
    endtask

    task automatic pulse_conv(input logic [15:0] v);
        convValue = v; convLoad = 1'b1;
        @(negedge clk);
        convLoad = 1'b0;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         acks;
        int         cw0, cs0;

        vecs[0] = '{8'h92, 8'h01, 16'hC383, 4, 16'hC383, 16'h8000, 16'h7FFF, 1, 1};
        vecs[1] = '{8'h92, 8'h02, 16'h0F0F, 4, 16'hC383, 16'h0F0F, 16'h7FFF, 0, 0};
        vecs[2] = '{8'h92, 8'h03, 16'h0055, 4, 16'hC383, 16'h0F0F, 16'h0055, 0, 0};
        vecs[3] = '{8'h92, 8'h05, 16'h1234, 4, 16'h9234, 16'h0F0F, 16'h0055, 1, 0};
        vecs[4] = '{8'h90, 8'h02, 16'hAAAA, 0, 16'h9234, 16'h0F0F, 16'h0055, 0, 0};
        vecs[5] = '{8'h92, 8'h00, 16'hFFFF, 4, 16'h9234, 16'h0F0F, 16'h0055, 0, 0};

        reset = 1'b1; tb_scl = 1'b1; tb_sda = 1'b1; convLoad = 1'b0; convValue = 16'd0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset isSending", {31'd0, isSending}, 32'd0);
        check("reset sdaOut", {31'd0, sdaOut}, 32'd1);
        check("reset configReg", {16'd0, configReg}, 32'h8583);
        check("reset loThresh", {16'd0, loThresh}, 32'h8000);
        check("reset hiThresh", {16'd0, hiThresh}, 32'h7FFF);
        check("reset pulses", {30'd0, configWritten, convStart}, 32'd0);

        // Repeated START after the pointer byte, then read register 1
        i2c_start();
        write_byte(8'h92, ack); check("rs addr ack", {31'd0, ack}, 32'd0);
        write_byte(8'h01, ack); check("rs ptr ack", {31'd0, ack}, 32'd0);
        i2c_start();
        write_byte(8'h93, ack); check("rs raddr ack", {31'd0, ack}, 32'd0);
        read_byte(rb, 1'b0); check("rs read msb", {24'd0, rb}, 32'h85);
        read_byte(rb, 1'b1); check("rs read lsb", {24'd0, rb}, 32'h83);
        i2c_stop();

        for (int v = 0; v < 6; v++) begin
            cw0 = cw_cnt; cs0 = cs_cnt; acks = 0;
            i2c_start();
            write_byte(vecs[v].addr, ack);      if (!ack) acks++;
            write_byte(vecs[v].ptr, ack);       if (!ack) acks++;
            write_byte(vecs[v].data[15:8], ack); if (!ack) acks++;
            write_byte(vecs[v].data[7:0], ack);  if (!ack) acks++;
            i2c_stop();
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d acks", v), acks, vecs[v].exp_acks);
            check($sformatf("vec%0d configReg", v), {16'd0, configReg}, {16'd0, vecs[v].exp_cfg});
            check($sformatf("vec%0d loThresh", v), {16'd0, loThresh}, {16'd0, vecs[v].exp_lo});
            check($sformatf("vec%0d hiThresh", v), {16'd0, hiThresh}, {16'd0, vecs[v].exp_hi});
            check($sformatf("vec%0d configWritten", v), cw_cnt - cw0, vecs[v].exp_cw);
            check($sformatf("vec%0d convStart", v), cs_cnt - cs0, vecs[v].exp_cs);
        end

        // Two byte pairs to the same pointer
        cw0 = cw_cnt; acks = 0;
        i2c_start();
        write_byte(8'h92, ack); if (!ack) acks++;
        write_byte(8'h02, ack); if (!ack) acks++;
        write_byte(8'h12, ack); if (!ack) acks++;
        write_byte(8'h34, ack); if (!ack) acks++;
        check("pair1 loThresh", {16'd0, loThresh}, 32'h1234);
        write_byte(8'h56, ack); if (!ack) acks++;
        write_byte(8'h78, ack); if (!ack) acks++;
        i2c_stop();
        check("pair2 loThresh", {16'd0, loThresh}, 32'h5678);
        check("pair acks", acks, 6);
        check("pair configWritten", cw_cnt - cw0, 0);

        // Conversion register load and read-back
        pulse_conv(16'hABCD);
        i2c_start();
        write_byte(8'h92, ack);
        write_byte(8'h00, ack);
        i2c_stop();
        i2c_start();
        write_byte(8'h93, ack); check("conv raddr ack", {31'd0, ack}, 32'd0);
        read_byte(rb, 1'b0); check("conv read msb", {24'd0, rb}, 32'hAB);
        read_byte(rb, 1'b1); check("conv read lsb", {24'd0, rb}, 32'hCD);
        repeat (4) @(negedge clk);
        check("nack isSending", {31'd0, isSending}, 32'd0);
        check("nack sda released", {31'd0, sdaIn}, 32'd1);
        i2c_stop();

        // Load between the two bytes must not tear the snapshot
        i2c_start();
        write_byte(8'h93, ack);
        read_byte(rb, 1'b0); check("snap msb", {24'd0, rb}, 32'hAB);
        pulse_conv(16'h1122);
        read_byte(rb, 1'b1); check("snap lsb", {24'd0, rb}, 32'hCD);
        i2c_stop();
        i2c_start();
        write_byte(8'h93, ack);
        read_byte(rb, 1'b0); check("reload msb", {24'd0, rb}, 32'h11);
        read_byte(rb, 1'b1); check("reload lsb", {24'd0, rb}, 32'h22);
        i2c_stop();

        // Reset while the target is driving a 0 data bit
        i2c_start();
        write_byte(8'h93, ack);
        check("mid-read driving", {30'd0, isSending, sdaOut}, 32'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset releases isSending", {31'd0, isSending}, 32'd0);
        check("reset releases sdaOut", {31'd0, sdaOut}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        read_byte(rb, 1'b1); check("post-reset ignore", {24'd0, rb}, 32'hFF);
        i2c_stop();
        check("post-reset configReg", {16'd0, configReg}, 32'h8583);
        check("post-reset loThresh", {16'd0, loThresh}, 32'h8000);
        i2c_start();
        write_byte(8'h93, ack); check("post-reset raddr ack", {31'd0, ack}, 32'd0);
        read_byte(rb, 1'b0); check("post-reset conv msb", {24'd0, rb}, 32'h00);
        read_byte(rb, 1'b1); check("post-reset conv lsb", {24'd0, rb}, 32'h00);
        i2c_stop();

`ifdef ADC_I2C_TARGET_TIMEOUT_EN
        i2c_start();
        write_byte(8'h93, ack);
        check("timeout pre driving", {31'd0, isSending}, 32'd1);
        repeat (320) @(negedge clk);
        check("timeout releases", {31'd0, isSending}, 32'd0);
        i2c_stop();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_i2c_target.md
Name: adc_i2c_target

Overview:
I2C target (responder) that emulates an ADS1115-style register map on the bus, so the existing I2C initiator/adc path can be exercised in loopback. It also lets the board act as an I2C peripheral for another host.
- Decodes START/STOP, address, pointer and data bytes from SCL/SDA.
- Drives SDA open-drain through the codebase's sdaOut/isSending convention.
- Holds four 16-bit registers; fabric writes the conversion register and reads back the config and threshold registers.

Parameters:
ADDRESS, 7'b1001001, 7-bit target address matched on the bus
CONFIG_RESET, 16'h8583, reset value of register 1 (config)
TIMEOUT_CYCLES, 32'd2700000, SCL-low timeout in clk cycles (used only with the optional feature)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
scl  input  1  raw bus SCL (asynchronous to clk)
sdaIn  input  1  raw bus SDA read-back (asynchronous to clk)
sdaOut  output  1  bit to drive; 0 pulls low, 1 releases
isSending  output  1  1 = target owns SDA (pad pulls low when isSending & ~sdaOut)
convValue  input  16  value for register 0
convLoad  input  1  1-cycle strobe: register 0 <= convValue
configReg  output  16  register 1
loThresh  output  16  register 2 (reset 16'h8000)
hiThresh  output  16  register 3 (reset 16'h7FFF)
configWritten  output  1  1-cycle pulse when the bus commits register 1
convStart  output  1  1-cycle pulse when a committed config write has bit 15 = 1

Behaviour:
- Input conditioning: scl and sdaIn each pass through a 2-flop synchronizer plus a history flop. Edges are detected on the synchronized signals, so internal latency is 2–3 clk from a pin change.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - Both are honoured in every state, including repeated START mid-transfer.
  - On either one: release SDA, bit counter = 0. START -> ADDR; STOP -> IDLE.
- Bits are sampled on the SCL rising edge, MSB first. The target changes SDA only on the SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: after 8 bits, compare the upper 7 bits with ADDRESS.
  - Match: ADDR_ACK. On the next SCL fall, isSending=1 and sdaOut=0 (ACK). Release on the following SCL fall.
  - Mismatch: IGNORE. No SDA activity until START or STOP.
- Write address (R/W=0): ADDR_ACK -> PTR. The pointer byte's bits [1:0] select the register; bits [7:2] are ignored. Always ACK, then -> WDATA with byteSel = MSB.
- WDATA: bytes alternate MSB, LSB, each ACKed.
  - The MSB is held; the register is committed on the LSB's 8th-bit sample.
  - Pointers 1–3 commit. Pointer 0 is ACKed but discarded.
  - Further byte pairs rewrite the same pointer.
- Config commit (pointer 1):
  - Stored bit 15 is always 1, and reads back 1.
  - configWritten pulses.
  - convStart pulses if the written bit 15 = 1.
- Read address (R/W=1): at the address ACK, snapshot the 16-bit register[pointer], so MSB and LSB are coherent. The pointer persists from the last write transaction; it resets to 0.
- RDATA:
  - Drive the snapshot MSB first, then LSB, each bit on an SCL fall.
  - isSending=1 during data bits; sdaOut=bit (1 releases).
  - Release SDA for the initiator's ACK slot (RDATA_ACK).
- RDATA_ACK:
  - Initiator ACK (0): continue, alternating MSB/LSB from the same snapshot.
  - Initiator NACK (1): -> IGNORE until STOP/START.
- convLoad is applied every cycle it is asserted. If it coincides with a read snapshot, the snapshot takes the pre-load value. Bus writes never touch register 0, so there is no conflict with convLoad.
- Reset values: all registers to defaults (reg0 = 0, reg1 = CONFIG_RESET, reg2 = 16'h8000, reg3 = 16'h7FFF), pointer = 0, state IDLE, isSending=0, sdaOut=1, pulses 0.
- Reset asserted mid-transfer: SDA is released the next cycle. After reset, the target ignores bus activity until a fresh START.
- The synchronized SDA value sampled while the target itself drives SDA is not used for START/STOP detection (a falling edge with SCL low is not a START).

Optional Feature:
ADC_I2C_TARGET_TIMEOUT_EN:
- Defined: a counter runs while synchronized SCL is low and state is not IDLE/IGNORE. On reaching TIMEOUT_CYCLES: release SDA (isSending=0), go to IDLE, keep registers unchanged. The counter clears on any SCL high.
- Undefined: no counter. The target waits indefinitely with SCL low; TIMEOUT_CYCLES is unused.

Test Plan:
- Write 0x92,0x01,0xC3,0x83 (addr 0x49 W, ptr 1, data 16'hC383) -> 4 ACKs; configReg = 16'hC383; configWritten and convStart each pulse once.
- Write 0x92,0x02,0x12,0x34,0x56,0x78 -> loThresh = 16'h1234 then 16'h5678; 6 ACKs; configWritten stays 0.
- convLoad with convValue = 16'hABCD; write ptr 0; read 0x93, initiator ACK, then NACK -> bytes 0xAB, 0xCD on SDA; SDA released after the NACK.
- Address 0x90 (0x48) -> no ACK (SDA stays released through the 9th clock); registers unchanged.
- Repeated START after the pointer byte, then read -> pointer 1 read returns 0x85,0x83 after reset.
- Reset asserted mid-read while driving 0 -> isSending = 0 within 1 cycle. Timeout build: SCL held low for TIMEOUT_CYCLES+1 -> IDLE and SDA released.
